// File: rtl/mat_pkg.sv
// Shared definitions for the matrix blocks: element width and the
// flattened-bus layout helpers used by mul_matrix and its neighbours.
package mat_pkg;

    localparam int ELEM_W = 32;

    // Bit offset of element (i,j) on an n x n flattened bus.
    // Element order on the bus is column-major: row index fastest.
    function automatic int elem_lsb(input int i, input int j, input int n);
        return (i + n * j) * ELEM_W;
    endfunction

    // Width of a row/column index for dimension n (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Two-level wrap counter walking an n x n index space. The fast index
// steps on every enable; when it wraps, the slow index steps. ROW_MAJOR
// selects whether the column (1) or the row (0) is the fast index.
module mat_index_counter
#(
    parameter int N         = 2,
    parameter bit ROW_MAJOR = 1'b0,
    parameter int IW        = 1
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic          last
);

    localparam logic [IW-1:0] MAX = IW'(N - 1);

    logic [IW-1:0] fast;
    logic [IW-1:0] slow;
    logic          fast_wrap;
    logic          slow_wrap;

    assign fast_wrap = (fast == MAX);
    assign slow_wrap = (slow == MAX);

    // Clear wins over enable so a capture always restarts at element 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fast <= '0;
            slow <= '0;
        end else if (clr) begin
            fast <= '0;
            slow <= '0;
        end else if (en) begin
            if (fast_wrap) begin
                fast <= '0;
                slow <= slow_wrap ? '0 : slow + IW'(1);
            end else begin
                fast <= fast + IW'(1);
            end
        end
    end

    assign row  = ROW_MAJOR ? slow : fast;
    assign col  = ROW_MAJOR ? fast : slow;
    assign last = fast_wrap && slow_wrap;

endmodule

// File: rtl/mat_stream_out.sv
// Captures an n x n matrix snapshot from the flattened bus on a start
// pulse and streams it out one element per valid/ready handshake, tagged
// with row, column and a last flag.
module mat_stream_out
    import mat_pkg::*;
#(
    parameter int  n         = 2,
    parameter bit  ROW_MAJOR = 1'b0,
    localparam int IW        = idx_w(n)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ELEM_W*n*n-1:0] mat_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_W-1:0]     out_data,
    output logic [IW-1:0]         out_row,
    output logic [IW-1:0]         out_col,
    output logic                  out_last,
    output logic                  done
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    logic                  state;
    logic [ELEM_W*n*n-1:0] snap;
    logic                  done_q;
    logic [IW-1:0]         row;
    logic [IW-1:0]         col;
    logic                  cnt_last;
    logic                  streaming;
    logic                  capture;
    logic                  hs;
    logic                  final_hs;
    logic [ELEM_W-1:0]     data_mux;

    assign streaming = (state == ST_STREAM);
    assign capture   = !streaming && start;
    assign hs        = streaming && out_ready;
    assign final_hs  = hs && cnt_last;

    mat_index_counter #(
        .N         (n),
        .ROW_MAJOR (ROW_MAJOR),
        .IW        (IW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .en    (hs),
        .row   (row),
        .col   (col),
        .last  (cnt_last)
    );

    // Two-state controller: IDLE waits for start, STREAM runs until the
    // last element is accepted. start during STREAM is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (capture) begin
            state <= ST_STREAM;
        end else if (final_hs) begin
            state <= ST_IDLE;
        end
    end

    // Snapshot register: loaded only on capture so later bus changes
    // cannot leak into a stream in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (capture) begin
            snap <= mat_in;
        end
    end

    // One-cycle completion pulse after the final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= final_hs;
        end
    end

    // Element select from the snapshot; decoded only from registered
    // counters so out_ready never reaches an output combinationally.
    always_comb begin
        data_mux = '0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                if (i == int'(row) && j == int'(col)) begin
                    data_mux = snap[elem_lsb(i, j, n) +: ELEM_W];
                end
            end
        end
    end

    assign busy      = streaming;
    assign out_valid = streaming;
    assign out_data  = data_mux;
    assign out_row   = row;
    assign out_col   = col;
    // Gated by STREAM so an n=1 instance does not flag last while idle.
    assign out_last  = streaming && cnt_last;
    assign done      = done_q;

endmodule

// File: tb/tb_mat_stream_out.sv
// Bench for mat_stream_out: three instances (n=2 column-major, n=2
// row-major, n=1) driven one at a time and checked against an
// expected element order computed from the index arithmetic.
module tb_mat_stream_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0]       st, rdy, bz, vl, ls, dn, rw, cl;
    logic [2:0][31:0] dt;
    logic [127:0]     mi_a, mi_b;
    logic [31:0]      mi_c;

    int total = 0;
    int bad   = 0;

    int unsigned mtx [3][2][2];
    int nn_of [3] = '{2, 2, 1};
    int rm_of [3] = '{0, 1, 0};

    mat_stream_out #(.n(2), .ROW_MAJOR(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .mat_in(mi_a), .busy(bz[0]),
        .out_valid(vl[0]), .out_ready(rdy[0]), .out_data(dt[0]), .out_row(rw[0]),
        .out_col(cl[0]), .out_last(ls[0]), .done(dn[0]));

    mat_stream_out #(.n(2), .ROW_MAJOR(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .mat_in(mi_b), .busy(bz[1]),
        .out_valid(vl[1]), .out_ready(rdy[1]), .out_data(dt[1]), .out_row(rw[1]),
        .out_col(cl[1]), .out_last(ls[1]), .done(dn[1]));

    mat_stream_out #(.n(1), .ROW_MAJOR(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .mat_in(mi_c), .busy(bz[2]),
        .out_valid(vl[2]), .out_ready(rdy[2]), .out_data(dt[2]), .out_row(rw[2]),
        .out_col(cl[2]), .out_last(ls[2]), .done(dn[2]));

    // Put matrix d (or all 7s) on that instance's bus, (i,j) at word i+n*j.
    task automatic drive_mat(input int d, input bit sevens);
        logic [127:0] v;
        int n;
        n = nn_of[d];
        v = '0;
        for (int j = 0; j < n; j++)
            for (int i = 0; i < n; i++)
                v = v | (128'(sevens ? 32'd7 : mtx[d][i][j]) << ((i + n * j) * 32));
        case (d)
            0: mi_a = v;
            1: mi_b = v;
            default: mi_c = v[31:0];
        endcase
    endtask

    task automatic rand_mat(input int d);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                mtx[d][i][j] = $urandom;
    endtask

    // mode 0: ready always; 1: ready pattern 0,0,1; 2: random ready.
    // poke: scramble bus + start mid-stream, and start on the final edge.
    task automatic stream(input int d, input int mode, input bit poke, output int cyc);
        int n, k, er, ec;
        bit r;
        int unsigned ed;
        n = nn_of[d];
        k = 0;
        cyc = 0;
        drive_mat(d, 1'b0);
        rdy[d] = 1'b0;
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
        while (k < n * n && cyc < 400) begin
            er = rm_of[d] ? k / n : k % n;
            ec = rm_of[d] ? k % n : k / n;
            ed = mtx[d][er][ec];
            total++;
            if (vl[d] !== 1'b1 || bz[d] !== 1'b1 || dn[d] !== 1'b0) begin
                bad++;
                $display("FAIL stream_ctl dut%0d k=%0d valid=%b busy=%b done=%b want 1 1 0",
                         d, k, vl[d], bz[d], dn[d]);
            end
            total++;
            if (dt[d] !== ed || rw[d] !== er[0] || cl[d] !== ec[0] || ls[d] !== (k == n * n - 1)) begin
                bad++;
                $display("FAIL stream_elem dut%0d k=%0d got data=%0d row=%0d col=%0d last=%b want %0d %0d %0d %b",
                         d, k, dt[d], rw[d], cl[d], ls[d], ed, er, ec, (k == n * n - 1));
            end
            case (mode)
                0: r = 1'b1;
                1: r = (cyc % 3 == 2);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (poke && cyc == 1) drive_mat(d, 1'b1);
            st[d] = poke && (cyc == 1 || (k == n * n - 1 && r));
            rdy[d] = r;
            @(negedge clk);
            cyc++;
            if (r) k++;
        end
        rdy[d] = 1'b0;
        st[d] = 1'b0;
        if (k < n * n) begin
            total++;
            bad++;
            $display("FAIL stream_timeout dut%0d accepted=%0d want %0d", d, k, n * n);
        end
        total++;
        if (dn[d] !== 1'b1 || bz[d] !== 1'b0 || vl[d] !== 1'b0 || ls[d] !== 1'b0) begin
            bad++;
            $display("FAIL stream_end dut%0d done=%b busy=%b valid=%b last=%b want 1 0 0 0",
                     d, dn[d], bz[d], vl[d], ls[d]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        st = '0;
        rdy = '0;
        mi_a = '0;
        mi_b = '0;
        mi_c = '0;
        #12;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (bz[d] !== 1'b0 || vl[d] !== 1'b0 || dt[d] !== 32'd0 || rw[d] !== 1'b0 ||
                cl[d] !== 1'b0 || ls[d] !== 1'b0 || dn[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d busy=%b valid=%b data=%0d row=%b col=%b last=%b done=%b want all 0",
                         d, bz[d], vl[d], dt[d], rw[d], cl[d], ls[d], dn[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plan_vector;
        int c;
        for (int d = 0; d < 2; d++) begin
            mtx[d][0][0] = 1; mtx[d][1][0] = 0; mtx[d][0][1] = 10; mtx[d][1][1] = 1;
            stream(d, 0, 1'b0, c);
            total++;
            if (c !== 4) begin
                bad++;
                $display("FAIL plan_busy_cycles dut%0d got %0d want 4", d, c);
            end
            @(negedge clk);
            total++;
            if (dn[d] !== 1'b0) begin
                bad++;
                $display("FAIL done_width dut%0d done=%b want 0", d, dn[d]);
            end
        end
    endtask

    task automatic test_backpressure;
        int c;
        for (int d = 0; d < 2; d++) begin
            rand_mat(d);
            stream(d, 1, 1'b0, c);
            total++;
            if (c !== 12) begin
                bad++;
                $display("FAIL bp_cycles dut%0d got %0d want 12", d, c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        int c;
        for (int it = 0; it < 6; it++) begin
            for (int d = 0; d < 2; d++) begin
                rand_mat(d);
                stream(d, 2, 1'b0, c);
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
    endtask

    task automatic test_isolation;
        int c;
        rand_mat(0);
        stream(0, 0, 1'b1, c);
        total++;
        if (c !== 4) begin
            bad++;
            $display("FAIL iso_cycles got %0d want 4", c);
        end
        // start right after the final handshake must be taken
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                mtx[0][i][j] = 7;
        stream(0, 0, 1'b0, c);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int c;
        rand_mat(0);
        drive_mat(0, 1'b0);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        rdy[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bz[0] !== 1'b0 || vl[0] !== 1'b0 || dt[0] !== 32'd0 || rw[0] !== 1'b0 ||
            cl[0] !== 1'b0 || ls[0] !== 1'b0 || dn[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid busy=%b valid=%b data=%0d row=%b col=%b last=%b done=%b want all 0",
                     bz[0], vl[0], dt[0], rw[0], cl[0], ls[0], dn[0]);
        end
        rdy[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (dn[0] !== 1'b0 || vl[0] !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_hold done=%b valid=%b want 0 0", dn[0], vl[0]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        rand_mat(0);
        stream(0, 2, 1'b0, c);
        @(negedge clk);
    endtask

    task automatic test_n1;
        int c;
        mtx[2][0][0] = 42;
        stream(2, 0, 1'b0, c);
        total++;
        if (c !== 1) begin
            bad++;
            $display("FAIL n1_cycles got %0d want 1", c);
        end
        @(negedge clk);
        rand_mat(2);
        stream(2, 2, 1'b0, c);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_plan_vector;
        test_backpressure;
        test_random;
        test_isolation;
        test_reset_mid;
        test_n1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mat_stream_out.md
# mat_stream_out

Sequential reader for the flattened 32-bit matrix bus produced by `mul_matrix`. On a start pulse it captures an n×n matrix snapshot and streams it out one element per handshake over a valid/ready interface, tagging each element with its row, column and a last flag. It sits on the output side of the multiplier and feeds word-wide consumers such as memory writers, UART framers or the next pipeline stage.

## Interface
Parameters:
- `n`, 2: matrix dimension; n ≥ 1.
- `ROW_MAJOR`, 0: element order. 0 = column-major (row index fastest, same as bus layout); 1 = row-major (column index fastest).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle capture request; honoured only while `busy`=0.
- `mat_in`  in  32·n·n  flattened matrix; element (i,j) occupies bits [(i+n·j)·32+31 : (i+n·j)·32].
- `busy`  out  1  high from the capture edge through the final handshake edge.
- `out_valid`  out  1  element present on `out_data`.
- `out_ready`  in  1  consumer accepts the element.
- `out_data`  out  32  current element.
- `out_row`  out  max(1,clog2 n)  row index i of the current element.
- `out_col`  out  max(1,clog2 n)  column index j of the current element.
- `out_last`  out  1  current element is the final (n·n-th) element.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM has two states, IDLE and STREAM. Reset enters IDLE.
- IDLE: `busy`=0, `out_valid`=0. If `start`=1, then on that edge:
  - register all of `mat_in` into the snapshot;
  - clear the row and column counters;
  - enter STREAM.
- STREAM: `busy`=1, `out_valid`=1. `out_data` = snapshot[row + n·col].
- A handshake occurs on any edge with `out_valid`=1 and `out_ready`=1.
- Counter advance on handshake:
  - ROW_MAJOR=0: row increments; when row reaches n-1 it wraps to 0 and col increments.
  - ROW_MAJOR=1: col increments; when col reaches n-1 it wraps to 0 and row increments.
- `out_last` = 1 when both row and col equal n-1.
- A handshake with `out_last`=1 returns the FSM to IDLE and sets `done` high for exactly the next cycle.
- Snapshot isolation: after capture, changes on `mat_in` do not affect the stream.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold their values.
- `start` while `busy`=1 is ignored. This includes the edge of the final handshake, which still sees `busy`=1.
- n=1: exactly one element, with `out_last`=1 on it; row and col stay 0.
- Data is a pure copy; no arithmetic or width change.

## Timing
- Reset (async assert, `rst_n` low): `busy`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `done`=0, snapshot=0, FSM=IDLE. Assertion aborts any stream immediately and no `done` is produced.
- Capture latency: `start` sampled at edge k → `out_valid`=1 with element 0 after edge k.
- Throughput: with `out_ready` held at 1, n·n elements transfer on n·n consecutive edges.
- `busy` falls and `done` rises after the final handshake edge.
- Earliest next `start` is sampled on the edge after the final handshake, so there is a minimum 1-cycle gap between streams.
- All outputs are registered, or decoded only from registered state; there is no combinational path from `out_ready` to any output.

## Structure
- Shared package `mat_pkg` holds:
  - `ELEM_W` = 32;
  - the index function `elem_lsb(i,j,n)` = (i+n·j)·32. `mul_matrix` and future matrix blocks use the same function.
- One sub-module, `mat_index_counter`:
  - two-level wrap counter (fast/slow index, n-bounded);
  - enable and clear inputs, plus a `last` output;
  - `ROW_MAJOR` selects which index is fast.
- The FSM, snapshot register and output mux stay in the top module.

## Test plan
- n=2, ROW_MAJOR=0, `mat_in` elements = {1,0,10,1}, `out_ready`=1, start pulse → data 1,0,10,1 with (row,col) = (0,0),(1,0),(0,1),(1,1). `out_last` is high on the 4th element only; `done` pulses 1 cycle later; `busy` is high for 4 cycles.
- Same matrix with ROW_MAJOR=1 → data 1,10,0,1 with (row,col) = (0,0),(0,1),(1,0),(1,1).
- Backpressure: toggle `out_ready` in a 0,0,1 pattern → each element is held stable for 3 cycles, the sequence is unchanged, and the total is 12 cycles.
- Isolation and ignore rules: change `mat_in` to all 7 and pulse `start` mid-stream → the original values are still emitted and no restart occurs. A `start` on the final-handshake edge is ignored. A `start` one cycle later is accepted.
- Reset mid-stream: drop `rst_n` after the 2nd handshake → all outputs read 0 immediately, with no `done`. After release, a new start streams from element 0.
- n=1, `mat_in`=42 → one element: 42 with (0,0) and `out_last`=1, then `done`.
